bcd_gated_freq_counter: RTL and testbench

- Multi-digit BCD event counter for the TTL frequency tester.
- Counts edges of an asynchronous TTL input only while a synchronous gate window is open.
- At gate close, latches the BCD total plus an overflow flag for the display/readout path.
- Generalises the single-decade cascade to DIGITS decades, adds a synchroniser, edge-mode selection, a window/latch sequence and overflow detection.

---
 rtl/bcd_gated_freq_counter_pkg.sv | 34 +++
 rtl/bcd_gated_freq_counter_if.sv | 28 ++
 rtl/bcd_gated_freq_counter_bcd_decade.sv | 42 ++++
 rtl/bcd_gated_freq_counter.sv | 118 +++++++++++
 tb/tb_bcd_gated_freq_counter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/bcd_gated_freq_counter_pkg.sv
// ---------------------------------------------------------------------------
// bcd_gated_freq_counter_pkg : shared constants and window-phase decode
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bcd_gated_freq_counter_pkg;

  localparam int          DIGIT_W   = 4;
  localparam logic [3:0]  BCD_MAX   = 4'd9;
  localparam int          EDGE_RISE = 0;
  localparam int          EDGE_BOTH = 1;

  typedef enum logic [1:0] {
    WIN_IDLE  = 2'd0,
    WIN_OPEN  = 2'd1,
    WIN_COUNT = 2'd2,
    WIN_CLOSE = 2'd3
  } win_phase_e;

  function automatic win_phase_e win_phase(input logic gate, input logic gate_d);
    win_phase_e ph;
    case ({gate, gate_d})
      2'b10:   ph = WIN_OPEN;
      2'b11:   ph = WIN_COUNT;
      2'b01:   ph = WIN_CLOSE;
      default: ph = WIN_IDLE;
    endcase
    return ph;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_gated_freq_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_gated_freq_counter_if : signal-in / gate / latched-result bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bcd_gated_freq_counter_if #(
  parameter int DIGITS = 6
);
  logic                  sig_in;
  logic                  gate;
  logic [4*DIGITS-1:0]   result;
  logic                  result_ovf;
  logic                  result_valid;
  logic                  busy;

  modport master (
    output sig_in, gate,
    input  result, result_ovf, result_valid, busy
  );

  modport slave (
    input  sig_in, gate,
    output result, result_ovf, result_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/bcd_gated_freq_counter_bcd_decade.sv
// ---------------------------------------------------------------------------
// bcd_decade : one 0-9 BCD digit with synchronous load and ripple carry
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_decade
  import bcd_gated_freq_counter_pkg::*;
(
  input  logic               clock,
  input  logic               clear,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               c_in,
  output logic               c_out,
  output logic [DIGIT_W-1:0] digit
);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (c_in) begin
      digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) digit_q <= '0;
    else       digit_q <= digit_d;
  end

  // Carry is combinational so the whole chain settles within one cycle.
  assign c_out = c_in & (digit_q == BCD_MAX);
  assign digit = digit_q;

endmodule

`default_nettype wire

// File: rtl/bcd_gated_freq_counter.sv
// ---------------------------------------------------------------------------
// bcd_gated_freq_counter : gated multi-decade BCD edge counter with latch
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_gated_freq_counter
  import bcd_gated_freq_counter_pkg::*;
#(
  parameter int DIGITS      = 6,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic                    clock,
  input  logic                    clear,
  bcd_gated_freq_counter_if.slave bus
);

  localparam int RES_W = DIGIT_W * DIGITS;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_d_q, s_d_d;
  logic                   gate_d_q, gate_d_d;
  logic                   sticky_ovf_q, sticky_ovf_d;
  logic [RES_W-1:0]       result_q, result_d;
  logic                   result_ovf_q, result_ovf_d;
  logic                   result_valid_q, result_valid_d;

  logic                   s;
  logic                   inc;
  win_phase_e             phase;
  logic                   load;
  logic [DIGITS:0]        carry;
  logic [RES_W-1:0]       count;

  assign s     = sync_q[SYNC_STAGES-1];
  assign phase = win_phase(bus.gate, gate_d_q);
  assign load  = (phase == WIN_OPEN);

  generate
    if (EDGE_MODE == EDGE_BOTH) begin : g_edge_both
      assign inc = s ^ s_d_q;
    end else begin : g_edge_rise
      assign inc = s & ~s_d_q;
    end
  endgenerate

  // Only the counting phase feeds the chain; open loads, close ignores inc.
  assign carry[0] = inc & (phase == WIN_COUNT);

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_decade
      logic [DIGIT_W-1:0] lv;
      if (g == 0) begin : g_lsd
        assign lv = {{(DIGIT_W-1){1'b0}}, inc};
      end else begin : g_upper
        assign lv = '0;
      end
      bcd_decade u_decade (
        .clock    (clock),
        .clear    (clear),
        .load     (load),
        .load_val (lv),
        .c_in     (carry[g]),
        .c_out    (carry[g+1]),
        .digit    (count[g*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  always_comb begin
    sync_d         = {sync_q[SYNC_STAGES-2:0], bus.sig_in};
    s_d_d          = s;
    gate_d_d       = bus.gate;
    sticky_ovf_d   = sticky_ovf_q;
    result_d       = result_q;
    result_ovf_d   = result_ovf_q;
    result_valid_d = 1'b0;
    case (phase)
      WIN_OPEN:  sticky_ovf_d = 1'b0;
      WIN_COUNT: if (carry[DIGITS]) sticky_ovf_d = 1'b1;
      WIN_CLOSE: begin
        result_d       = count;
        result_ovf_d   = sticky_ovf_q;
        result_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      sync_q         <= '0;
      s_d_q          <= 1'b0;
      gate_d_q       <= 1'b0;
      sticky_ovf_q   <= 1'b0;
      result_q       <= '0;
      result_ovf_q   <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      s_d_q          <= s_d_d;
      gate_d_q       <= gate_d_d;
      sticky_ovf_q   <= sticky_ovf_d;
      result_q       <= result_d;
      result_ovf_q   <= result_ovf_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.result       = result_q;
  assign bus.result_ovf   = result_ovf_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = gate_d_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_gated_freq_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_gated_freq_counter : three configurations driven by shared stimulus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bcd_gated_freq_counter;

  logic clk;
  logic clear;
  logic sig;
  logic gate;

  int checks   = 0;
  int failures = 0;

  bcd_gated_freq_counter_if #(.DIGITS(4)) if4r ();
  bcd_gated_freq_counter_if #(.DIGITS(2)) if2r ();
  bcd_gated_freq_counter_if #(.DIGITS(4)) if4b ();

  assign if4r.sig_in = sig;  assign if4r.gate = gate;
  assign if2r.sig_in = sig;  assign if2r.gate = gate;
  assign if4b.sig_in = sig;  assign if4b.gate = gate;

  bcd_gated_freq_counter #(.DIGITS(4), .SYNC_STAGES(2), .EDGE_MODE(0)) dut4r (
    .clock(clk), .clear(clear), .bus(if4r)
  );
  bcd_gated_freq_counter #(.DIGITS(2), .SYNC_STAGES(2), .EDGE_MODE(0)) dut2r (
    .clock(clk), .clear(clear), .bus(if2r)
  );
  bcd_gated_freq_counter #(.DIGITS(4), .SYNC_STAGES(2), .EDGE_MODE(1)) dut4b (
    .clock(clk), .clear(clear), .bus(if4b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  typedef struct {
    int          n;
    logic [15:0] exp4r;
    logic [7:0]  exp2r;
    logic        ovf2r;
    logic [15:0] exp4b;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) begin
      sig = 1'b1; tick(2);
      sig = 1'b0; tick(2);
    end
  endtask

  logic [15:0] prev4r, prev4b;
  logic [7:0]  prev2r;

  initial begin
    vecs[0] = '{37,  16'h0037, 8'h37, 1'b0, 16'h0074};
    vecs[1] = '{100, 16'h0100, 8'h00, 1'b1, 16'h0200};
    vecs[2] = '{5,   16'h0005, 8'h05, 1'b0, 16'h0010};
    vecs[3] = '{12,  16'h0012, 8'h12, 1'b0, 16'h0024};
    vecs[4] = '{9,   16'h0009, 8'h09, 1'b0, 16'h0018};
    vecs[5] = '{99,  16'h0099, 8'h99, 1'b0, 16'h0198};

    clear = 1'b1; sig = 1'b0; gate = 1'b0;
    tick(3);
    #1;
    chk("reset_result4r", {16'h0, if4r.result}, 32'h0);
    chk("reset_result2r", {24'h0, if2r.result}, 32'h0);
    chk("reset_flags4r", {29'h0, if4r.result_ovf, if4r.result_valid, if4r.busy}, 32'h0);
    clear = 1'b0;
    tick(2);

    prev4r = 16'h0; prev2r = 8'h0; prev4b = 16'h0;
    for (int v = 0; v < 6; v++) begin
      gate = 1'b1;
      tick(2);
      chk($sformatf("busy_open_%0d", v), {31'h0, if4r.busy}, 32'h1);
      pulses(vecs[v].n);
      tick(4);
      // Previous window's result must still be held right up to the close.
      chk($sformatf("hold4r_%0d", v), {16'h0, if4r.result}, {16'h0, prev4r});
      chk($sformatf("hold2r_%0d", v), {24'h0, if2r.result}, {24'h0, prev2r});
      gate = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("valid4r_%0d", v), {31'h0, if4r.result_valid}, 32'h1);
      chk($sformatf("res4r_%0d", v), {16'h0, if4r.result}, {16'h0, vecs[v].exp4r});
      chk($sformatf("ovf4r_%0d", v), {31'h0, if4r.result_ovf}, 32'h0);
      chk($sformatf("res2r_%0d", v), {24'h0, if2r.result}, {24'h0, vecs[v].exp2r});
      chk($sformatf("ovf2r_%0d", v), {31'h0, if2r.result_ovf}, {31'h0, vecs[v].ovf2r});
      chk($sformatf("res4b_%0d", v), {16'h0, if4b.result}, {16'h0, vecs[v].exp4b});
      chk($sformatf("ovf4b_%0d", v), {31'h0, if4b.result_ovf}, 32'h0);
      @(posedge clk); #1;
      chk($sformatf("valid_drop_%0d", v), {31'h0, if4r.result_valid}, 32'h0);
      prev4r = vecs[v].exp4r; prev2r = vecs[v].exp2r; prev4b = vecs[v].exp4b;
      tick(2);
    end

    // Asynchronous clear in the middle of an open window, between clock edges.
    gate = 1'b1;
    tick(2);
    pulses(3);
    sig = 1'b1;
    #2;
    clear = 1'b1;
    #1;
    chk("aclr_result", {16'h0, if4r.result}, 32'h0);
    chk("aclr_flags", {29'h0, if4r.result_ovf, if4r.result_valid, if4r.busy}, 32'h0);
    chk("aclr_result4b", {16'h0, if4b.result}, 32'h0);
    gate = 1'b0; sig = 1'b0;
    tick(2);
    clear = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("aclr_novalid_%0d", c), {30'h0, if4r.result_valid, if2r.result_valid}, 32'h0);
    end
    tick(2);

    // inc lands exactly on the open cycle and again on the close cycle.
    sig = 1'b1;
    tick(2);
    gate = 1'b1; sig = 1'b0;
    tick(2);
    pulses(3);
    sig = 1'b1;
    tick(2);
    gate = 1'b0; sig = 1'b0;
    @(posedge clk); #1;
    chk("coinc_valid", {31'h0, if4r.result_valid}, 32'h1);
    chk("coinc_result", {16'h0, if4r.result}, 32'h0004);
    chk("coinc_ovf", {31'h0, if4r.result_ovf}, 32'h0);
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
